// File: rtl/fe_fetch_buf_pkg.sv
// Shared types for the FE <-> fetch buffer <-> memory fill path.
//   t_fe_fb_req  : {valid, addr, id} fetch request from FE
//   t_fb_fe_rsp  : {valid, instr, pc} same-cycle fetch response
//   t_fb_mem_req : {valid, addr} line fill request (line-aligned addr)
//   t_mem_fb_rsp : {valid, addr, data} line fill return
//   t_fsm_fb     : fill FSM states
package fe_fetch_buf_pkg;

    localparam int unsigned PADDR         = 32;
    localparam int unsigned FE_ID_W       = 4;
    localparam int unsigned FB_LINE_BYTES = 64;
    localparam int unsigned FB_OFF_W      = $clog2(FB_LINE_BYTES);
    localparam int unsigned FB_TAG_W      = PADDR - FB_OFF_W;

    typedef logic [FB_LINE_BYTES*8-1:0] t_fb_line;
    typedef logic [FB_TAG_W-1:0]        t_fb_tag;

    typedef struct packed {
        logic               valid;
        logic [PADDR-1:0]   addr;
        logic [FE_ID_W-1:0] id;
    } t_fe_fb_req;

    typedef struct packed {
        logic             valid;
        logic [31:0]      instr;
        logic [PADDR-1:0] pc;
    } t_fb_fe_rsp;

    typedef struct packed {
        logic             valid;
        logic [PADDR-1:0] addr;
    } t_fb_mem_req;

    typedef struct packed {
        logic             valid;
        logic [PADDR-1:0] addr;
        t_fb_line         data;
    } t_mem_fb_rsp;

    typedef enum logic [1:0] {FB_IDLE, FB_REQ, FB_WAIT, FB_DRAIN} t_fsm_fb;

    function automatic t_fb_tag line_tag(input logic [PADDR-1:0] addr);
        return addr[PADDR-1:FB_OFF_W];
    endfunction

endpackage

// File: rtl/fe_fb_entry.sv
// One fetch-buffer line entry: valid bit, line tag and line data, with a tag compare.
//   clk, reset    : clock, synchronous active-high reset
//   flush         : clear the valid bit next cycle
//   install       : write install_tag/install_data and set valid
//   lookup_tag    : tag to compare against
//   valid         : entry holds a line
//   hit           : valid and tag matches lookup_tag
//   data          : stored line
module fe_fb_entry
    import fe_fetch_buf_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     install,
    input  t_fb_tag  install_tag,
    input  t_fb_line install_data,
    input  t_fb_tag  lookup_tag,
    output logic     valid,
    output logic     hit,
    output t_fb_line data
);

    logic     valid_q;
    t_fb_tag  tag_q;
    t_fb_line data_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= 1'b0;
        end else if (install) begin
            valid_q <= 1'b1;
        end
    end

    // Payload needs no reset; it is only observed through valid_q.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q  <= install_tag;
            data_q <= install_data;
        end
    end

    assign valid = valid_q;
    assign hit   = valid_q && (tag_q == lookup_tag);
    assign data  = data_q;

endmodule

// File: rtl/fe_fetch_buf.sv
// Fetch buffer: responder side of FE->FB. Returns the instruction at the requested PC in the
// same cycle on a hit; on a miss fetches one line from memory with a single outstanding fill.
//   clk, reset      : clock, synchronous active-high reset
//   fe_fb_req_fb0   : fetch request from FE (held stable until rsp.valid)
//   fb_fe_rsp_fb0   : same-cycle response
//   flush_fb        : invalidate all entries, cancel pending fill
//   fb_mem_req      : line fill request
//   mem_fb_req_rdy  : memory accepts fb_mem_req this cycle
//   mem_fb_rsp      : line fill return
module fe_fetch_buf
    import fe_fetch_buf_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned LINE_BYTES  = FB_LINE_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  t_fe_fb_req  fe_fb_req_fb0,
    output t_fb_fe_rsp  fb_fe_rsp_fb0,
    input  logic        flush_fb,
    output t_fb_mem_req fb_mem_req,
    input  logic        mem_fb_req_rdy,
    input  t_mem_fb_rsp mem_fb_rsp
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    if (LINE_BYTES != FB_LINE_BYTES || NUM_ENTRIES < 2 ||
        (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0) begin : g_bad_param
        $error("fe_fetch_buf: unsupported NUM_ENTRIES/LINE_BYTES");
    end

    t_fsm_fb          state_q;
    logic [PADDR-1:0] fill_addr_q;
    logic [IDX_W-1:0] rr_ptr_q;

    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [NUM_ENTRIES-1:0] ent_hit;
    logic [NUM_ENTRIES-1:0] ent_install;
    t_fb_line               ent_data [NUM_ENTRIES];

    t_fb_tag             req_tag;
    logic                hit;
    logic                miss;
    logic                fill_match;
    logic                install;
    logic [IDX_W-1:0]    victim;
    logic                victim_uses_rr;
    t_fb_line            hit_line;
    logic [FB_OFF_W-3:0] word_idx;
    logic                unused_id;

    assign unused_id = ^fe_fb_req_fb0.id;

    assign req_tag  = line_tag(fe_fb_req_fb0.addr);
    assign word_idx = fe_fb_req_fb0.addr[FB_OFF_W-1:2];
    assign hit      = fe_fb_req_fb0.valid && (|ent_hit);
    assign miss     = fe_fb_req_fb0.valid && !(|ent_hit);

    // A return only counts when it matches the outstanding line; anything else is stray.
    assign fill_match = mem_fb_rsp.valid && (mem_fb_rsp.addr == fill_addr_q);
    // Flush in the return cycle drops the data.
    assign install    = (state_q == FB_WAIT) && fill_match && !flush_fb;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        assign ent_install[g] = install && (victim == IDX_W'(g));

        fe_fb_entry u_entry (
            .clk          (clk),
            .reset        (reset),
            .flush        (flush_fb),
            .install      (ent_install[g]),
            .install_tag  (line_tag(fill_addr_q)),
            .install_data (mem_fb_rsp.data),
            .lookup_tag   (req_tag),
            .valid        (ent_valid[g]),
            .hit          (ent_hit[g]),
            .data         (ent_data[g])
        );
    end

    // Lowest-index invalid entry wins; round-robin only once all entries are valid.
    always_comb begin
        victim         = rr_ptr_q;
        victim_uses_rr = 1'b1;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                victim         = IDX_W'(i);
                victim_uses_rr = 1'b0;
            end
        end
    end

    // At most one entry hits, so OR-ing the hitting lines selects it.
    always_comb begin
        hit_line = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_hit[i]) begin
                hit_line = hit_line | ent_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FB_IDLE;
            fill_addr_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            if (install && victim_uses_rr) begin
                rr_ptr_q <= rr_ptr_q + 1'b1;
            end
            unique case (state_q)
                FB_IDLE: begin
                    if (miss && !flush_fb) begin
                        state_q     <= FB_REQ;
                        fill_addr_q <= {req_tag, {FB_OFF_W{1'b0}}};
                    end
                end
                FB_REQ: begin
                    if (flush_fb) begin
                        state_q <= FB_IDLE;
                    end else if (mem_fb_req_rdy) begin
                        state_q <= FB_WAIT;
                    end
                end
                FB_WAIT: begin
                    if (fill_match) begin
                        state_q <= FB_IDLE;
                    end else if (flush_fb) begin
                        state_q <= FB_DRAIN;
                    end
                end
                FB_DRAIN: begin
                    if (fill_match) begin
                        state_q <= FB_IDLE;
                    end
                end
                default: state_q <= FB_IDLE;
            endcase
        end
    end

    always_comb begin
        fb_fe_rsp_fb0 = '0;
        fb_mem_req    = '0;
        if (!reset) begin
            fb_fe_rsp_fb0.valid = hit && !flush_fb;
            fb_fe_rsp_fb0.pc    = fe_fb_req_fb0.addr;
            fb_fe_rsp_fb0.instr = hit_line[{word_idx, 5'd0} +: 32];
            // Withdrawn in the flush cycle so memory never accepts a cancelled fill.
            fb_mem_req.valid    = (state_q == FB_REQ) && !flush_fb;
            fb_mem_req.addr     = fill_addr_q;
        end
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (reset)
        fe_fb_req_fb0.valid |-> (fe_fb_req_fb0.addr[1:0] == 2'b00));

    a_hit_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(ent_hit));

endmodule

// File: tb/tb_fe_fetch_buf.sv
// Scoreboard bench for fe_fetch_buf: stimulus pushes expected responses / fill requests,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_fe_fetch_buf;
    import fe_fetch_buf_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_rsp_t;

    logic        clk;
    logic        reset;
    t_fe_fb_req  req;
    t_fb_fe_rsp  rsp;
    logic        flush;
    t_fb_mem_req mreq;
    logic        mem_rdy;
    t_mem_fb_rsp mem_rsp;

    int total = 0;
    int bad   = 0;

    exp_rsp_t    rsp_q[$];
    logic [31:0] mreq_q[$];

    fe_fetch_buf #(
        .NUM_ENTRIES (4),
        .LINE_BYTES  (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fe_fb_req_fb0  (req),
        .fb_fe_rsp_fb0  (rsp),
        .flush_fb       (flush),
        .fb_mem_req     (mreq),
        .mem_fb_req_rdy (mem_rdy),
        .mem_fb_rsp     (mem_rsp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Memory contents: each word encodes its own byte address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic t_fb_line line_of(input logic [31:0] l);
        t_fb_line d;
        for (int w = 0; w < 16; w++) begin
            d[w*32 +: 32] = word_of(l + 32'(w * 4));
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: compares every response and every accepted fill request against the queues.
    always @(negedge clk) begin
        if (rsp.valid) begin
            total++;
            if (rsp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got pc=%h instr=%h want none", rsp.pc, rsp.instr);
            end else begin
                exp_rsp_t e;
                e = rsp_q.pop_front();
                if (rsp.pc !== e.pc || rsp.instr !== e.instr) begin
                    bad++;
                    $display("FAIL rsp got pc=%h instr=%h want pc=%h instr=%h",
                             rsp.pc, rsp.instr, e.pc, e.instr);
                end
            end
        end
        if (mreq.valid && mem_rdy) begin
            total++;
            if (mreq_q.size() == 0) begin
                bad++;
                $display("FAIL mem_req_unexpected got addr=%h want none", mreq.addr);
            end else begin
                logic [31:0] ea;
                ea = mreq_q.pop_front();
                if (mreq.addr !== ea) begin
                    bad++;
                    $display("FAIL mem_req got addr=%h want addr=%h", mreq.addr, ea);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req_set(input logic [31:0] a);
        req.valid = 1'b1;
        req.addr  = a;
        req.id    = a[5:2];
    endtask

    task automatic req_clr();
        req = '0;
    endtask

    task automatic drive_fill(input logic [31:0] l);
        mem_rsp.valid = 1'b1;
        mem_rsp.addr  = l;
        mem_rsp.data  = line_of(l);
    endtask

    // Single hit: response expected in the request cycle.
    task automatic fetch_hit(input logic [31:0] a);
        rsp_q.push_back('{pc: a, instr: word_of(a)});
        req_set(a);
        step(1);
        req_clr();
    endtask

    // Miss: one fill request (after 'stall' cycles of backpressure), fill returns 3 cycles
    // after acceptance, response the cycle after the fill.
    task automatic miss_fill(input logic [31:0] a, input int stall);
        logic [31:0] l;
        l = a & ~32'h3F;
        mreq_q.push_back(l);
        rsp_q.push_back('{pc: a, instr: word_of(a)});
        mem_rdy = (stall == 0);
        req_set(a);
        step(1);
        for (int i = 0; i < stall; i++) begin
            #2;
            check("mem_req_held", {31'd0, mreq.valid, mreq.addr}, {31'd0, 1'b1, l});
            step(1);
        end
        #2;
        check("mem_req_issue", {31'd0, mreq.valid, mreq.addr}, {31'd0, 1'b1, l});
        mem_rdy = 1'b1;
        step(1);
        step(2);
        drive_fill(l);
        step(1);
        mem_rsp = '0;
        step(1);
        req_clr();
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        flush   = 1'b0;
        mem_rdy = 1'b1;
        mem_rsp = '0;
        step(2);
        #2;
        check("reset_rsp", 64'(rsp), 64'd0);
        check("reset_mem_req", 64'(mreq), 64'd0);
        step(1);
        reset = 1'b0;
        step(1);

        // Cold miss then sequential hits across the line, then next line misses.
        miss_fill(32'h1000, 0);
        for (int i = 1; i < 16; i++) begin
            fetch_hit(32'h1000 + 32'(i * 4));
        end
        miss_fill(32'h1040, 0);

        // Flush forces rsp.valid low even on a hitting request.
        req_set(32'h1000);
        flush = 1'b1;
        #2;
        check("flush_kills_rsp", {63'd0, rsp.valid}, 64'd0);
        step(1);
        flush = 1'b0;
        req_clr();

        // Capacity and round-robin replacement.
        miss_fill(32'h0000, 0);
        miss_fill(32'h0040, 0);
        miss_fill(32'h0080, 0);
        miss_fill(32'h00C0, 0);
        fetch_hit(32'h0004);
        miss_fill(32'h0100, 0);
        fetch_hit(32'h0044);
        miss_fill(32'h0140, 0);
        fetch_hit(32'h0080);
        fetch_hit(32'h00C0);
        fetch_hit(32'h0108);
        fetch_hit(32'h0144);
        miss_fill(32'h0000, 0);
        miss_fill(32'h0040, 0);
        fetch_hit(32'h013C);

        // Backpressure on the fill request.
        miss_fill(32'h2004, 5);
        fetch_hit(32'h2000);

        // Flush while the fill is outstanding; the late return is discarded.
        mreq_q.push_back(32'h3000);
        req_set(32'h3000);
        step(2);
        flush = 1'b1;
        req_clr();
        step(1);
        flush = 1'b0;
        step(1);
        drive_fill(32'h3000);
        step(1);
        mem_rsp = '0;
        miss_fill(32'h3000, 0);

        // Flush before the request is accepted withdraws it.
        mem_rdy = 1'b0;
        req_set(32'h3400);
        step(1);
        flush = 1'b1;
        req_clr();
        step(1);
        flush = 1'b0;
        #2;
        check("req_withdrawn", {63'd0, mreq.valid}, 64'd0);
        mem_rdy = 1'b1;
        step(2);
        check("no_req_after_withdraw", {63'd0, mreq.valid}, 64'd0);

        // Flush coincident with the fill return: data dropped, FSM back to idle.
        mreq_q.push_back(32'h3800);
        req_set(32'h3800);
        step(3);
        flush = 1'b1;
        req_clr();
        drive_fill(32'h3800);
        step(1);
        flush   = 1'b0;
        mem_rsp = '0;
        miss_fill(32'h3800, 0);

        // Reset mid-fill, with a hitting request in the reset cycle, then a stray return.
        mreq_q.push_back(32'h5000);
        req_set(32'h5000);
        step(2);
        reset = 1'b1;
        req_set(32'h3800);
        #2;
        check("reset_mid_rsp", 64'(rsp), 64'd0);
        check("reset_mid_mem_req", 64'(mreq), 64'd0);
        step(1);
        req_clr();
        step(1);
        reset = 1'b0;
        drive_fill(32'h5000);
        step(1);
        mem_rsp = '0;
        step(1);
        miss_fill(32'h3800, 0);
        miss_fill(32'h5000, 0);

        step(2);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        check("mreq_q_drained", 64'(mreq_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
